// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
//   Shared definitions for the 320x240 RGB444 frame buffer: geometry,
//   address/pixel widths, the writer FIFO entry layout and the BRAM port
//   arbitration states.
// ---------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int FB_DEPTH = FB_W * FB_H;   // valid addresses 0..FB_DEPTH-1
   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 12;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] pixel_t;

   // One queued writer pixel.
   typedef struct packed {
      addr_t  addr;
      pixel_t data;
   } fb_wr_entry_t;

   // What the BRAM port is doing in the next cycle.
   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_DISP,
      ARB_WRITE
   } arb_state_t;

   // Unsigned compare of an address against the frame-buffer size.
   function automatic logic addr_in_range(input addr_t a);
      return a < addr_t'(FB_DEPTH);
   endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo
//   Small synchronous FIFO holding {addr,data} writer pixels until the BRAM
//   port is free. DEPTH must be a power of two so the pointers wrap by
//   simple overflow.
//
// Ports
//   clk         in   1        system clock
//   reset       in   1        synchronous, active-high; empties the FIFO
//   push        in   1        enqueue push_entry (caller guarantees !full)
//   push_entry  in   entry    pixel to enqueue
//   pop         in   1        dequeue head (caller guarantees !empty)
//   head        out  entry    oldest entry, valid while !empty
//   full        out  1        count == DEPTH
//   empty       out  1        count == 0
//   count       out  CNT_W    number of stored entries
// ---------------------------------------------------------------------------
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  fb_wr_entry_t                 push_entry,
   input  logic                         pop,
   output fb_wr_entry_t                 head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   fb_wr_entry_t       storage [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   // NOTE: the storage array has no reset; the pointers and count define
   // which entries are live, so clearing them is enough and the array maps
   // onto plain distributed RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr] <= push_entry;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Simultaneous push and pop leave the count unchanged.
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = storage[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter
//   Shares the single-port frame-buffer BRAM between the display read path
//   and a pixel writer. Display reads have absolute priority and a fixed
//   2-cycle request-to-data latency. Writer pixels are queued in a small
//   FIFO that drains only in cycles without a display request. Out-of-range
//   writer pixels are accepted, dropped and flagged on the sticky oob_err.
//   wr_starved is a diagnostic that reports a FIFO held full for a long time.
//
// Ports
//   clk          in   1       system clock
//   reset        in   1       synchronous, active-high
//   disp_req     in   1       display read this cycle
//   disp_addr    in   ADDR_W  display read address
//   disp_data    out  DATA_W  pixel to the display, 0 when !disp_valid
//   disp_valid   out  1       disp_data valid
//   wr_valid     in   1       writer offers a pixel
//   wr_ready     out  1       FIFO can accept a pixel
//   wr_addr      in   ADDR_W  writer pixel address
//   wr_data      in   DATA_W  writer pixel data
//   mem_addr     out  ADDR_W  BRAM address (registered)
//   mem_we       out  1       BRAM write enable (registered)
//   mem_wdata    out  DATA_W  BRAM write data (registered)
//   mem_rdata    in   DATA_W  BRAM read data, one cycle after mem_addr
//   oob_err      out  1       sticky: an out-of-range writer pixel was seen
//   wr_starved   out  1       FIFO full for >= STARVE_LIM cycles
// ---------------------------------------------------------------------------
module frame_buffer_arbiter
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_LIM = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                disp_req,
   input  logic [ADDR_W-1:0]   disp_addr,
   output logic [DATA_W-1:0]   disp_data,
   output logic                disp_valid,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                oob_err,
   output logic                wr_starved
);

   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int STARVE_W = $clog2(STARVE_LIM + 1);

   // ----------------------------------------------------------------------
   // Writer handshake and FIFO
   // ----------------------------------------------------------------------
   logic               wr_accept;
   logic               wr_in_range;
   logic               fifo_push;
   logic               fifo_pop;
   fb_wr_entry_t       fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   // Ready comes straight from the count, so it drops in the same cycle the
   // FIFO fills and the writer can never push into a full FIFO.
   assign wr_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign wr_accept   = wr_valid && wr_ready;
   assign wr_in_range = addr_in_range(wr_addr);
   // Out-of-range pixels complete the handshake but never reach the FIFO.
   assign fifo_push   = wr_accept && wr_in_range;

   fb_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry ('{addr: wr_addr, data: wr_data}),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // ----------------------------------------------------------------------
   // Port arbitration: display first, then queued writes, else idle.
   // ----------------------------------------------------------------------
   arb_state_t    arb_state;
   arb_state_t    arb_nxt;
   addr_t         mem_addr_nxt;
   pixel_t        mem_wdata_nxt;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      arb_nxt       = ARB_IDLE;
      fifo_pop      = 1'b0;
      mem_addr_nxt  = mem_addr;    // IDLE holds the last address
      mem_wdata_nxt = mem_wdata;

      if (disp_req) begin
         arb_nxt      = ARB_DISP;
         mem_addr_nxt = disp_addr;
      end else if (!fifo_empty) begin
         arb_nxt       = ARB_WRITE;
         fifo_pop      = 1'b1;
         mem_addr_nxt  = fifo_head.addr;
         mem_wdata_nxt = fifo_head.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         arb_state <= ARB_IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         arb_state <= arb_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

   // The write enable is simply "the port is in a write cycle".
   assign mem_we = (arb_state == ARB_WRITE);

   // ----------------------------------------------------------------------
   // Display read pipeline: request -> mem_addr (+1) -> mem_rdata (+2).
   // ----------------------------------------------------------------------
   logic [1:0] rd_pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe <= {rd_pipe[0], disp_req};
      end
   end

   assign disp_valid = rd_pipe[1];
   assign disp_data  = rd_pipe[1] ? mem_rdata : '0;

   // ----------------------------------------------------------------------
   // Sticky out-of-range flag.
   // ----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         oob_err <= 1'b0;
      end else if (wr_accept && !wr_in_range) begin
         oob_err <= 1'b1;
      end
   end

   // ----------------------------------------------------------------------
   // Starvation diagnostic: counts consecutive full cycles, saturating at
   // the limit so it never wraps back below it.
   // ----------------------------------------------------------------------
   logic [STARVE_W-1:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!fifo_full) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_W'(STARVE_LIM)) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

   assign wr_starved = (starve_cnt >= STARVE_W'(STARVE_LIM));

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_arbiter
//   Table-driven vectors, hand-written corner sequences and a random run,
//   all cross-checked every cycle against a queue-based reference model of
//   the arbiter. A simple read-first BRAM model answers the memory port.
// ---------------------------------------------------------------------------
module tb_frame_buffer_arbiter;
   import fb_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int STARVE_LIM = 1024;

   logic    clk = 1'b0;
   logic    reset = 1'b1;
   logic    disp_req = 1'b0;
   addr_t   disp_addr = '0;
   pixel_t  disp_data;
   logic    disp_valid;
   logic    wr_valid = 1'b0;
   logic    wr_ready;
   addr_t   wr_addr = '0;
   pixel_t  wr_data = '0;
   addr_t   mem_addr;
   logic    mem_we;
   pixel_t  mem_wdata;
   pixel_t  mem_rdata = '0;
   logic    oob_err;
   logic    wr_starved;

   always #5 clk = ~clk;

   frame_buffer_arbiter #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .oob_err    (oob_err),
      .wr_starved (wr_starved)
   );

   // Single-port read-first BRAM with one cycle of read latency.
   pixel_t bram [FB_DEPTH];
   bit     bram_oob_wr = 1'b0;

   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_addr < addr_t'(FB_DEPTH)) bram[mem_addr] <= mem_wdata;
         else                              bram_oob_wr <= 1'b1;
      end
      mem_rdata <= (mem_addr < addr_t'(FB_DEPTH)) ? bram[mem_addr] : '0;
   end

   // ----------------------------------------------------------------------
   // Checking
   // ----------------------------------------------------------------------
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ----------------------------------------------------------------------
   // Reference model: a queue of pending pixels plus a shadow of memory.
   // ----------------------------------------------------------------------
   typedef struct { addr_t addr; pixel_t data; } px_t;

   px_t     mq[$];
   addr_t   m_addr = '0;
   pixel_t  m_wdata = '0;
   bit      m_we = 1'b0;
   bit      m_pv0 = 1'b0, m_pv1 = 1'b0;
   pixel_t  m_pd0 = '0, m_pd1 = '0;
   bit      m_oob = 1'b0;
   int      m_full_cycles = 0;
   pixel_t  shadow [FB_DEPTH];

   // Apply the current inputs for one clock, then compare every output.
   task automatic tick();
      px_t px;
      bit  full;
      bit  acc;
      if (reset) begin
         mq.delete();
         m_addr = '0; m_wdata = '0; m_we = 1'b0;
         m_pv0 = 1'b0; m_pv1 = 1'b0;
         m_oob = 1'b0; m_full_cycles = 0;
      end else begin
         full = (mq.size() == FIFO_DEPTH);
         acc  = wr_valid && !full;
         if (full) m_full_cycles = (m_full_cycles < STARVE_LIM) ? m_full_cycles + 1 : m_full_cycles;
         else      m_full_cycles = 0;
         m_pv1 = m_pv0; m_pd1 = m_pd0;
         m_pv0 = disp_req;
         m_pd0 = disp_req ? shadow[disp_addr] : '0;
         if (disp_req) begin
            m_we = 1'b0; m_addr = disp_addr;
         end else if (mq.size() != 0) begin
            px = mq.pop_front();
            m_we = 1'b1; m_addr = px.addr; m_wdata = px.data;
            shadow[px.addr] = px.data;
         end else begin
            m_we = 1'b0;
         end
         if (acc) begin
            if (wr_addr < addr_t'(FB_DEPTH)) mq.push_back('{addr: wr_addr, data: wr_data});
            else                             m_oob = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check("model.mem_we", mem_we, m_we);
      check("model.mem_addr", mem_addr, m_addr);
      if (m_we) check("model.mem_wdata", mem_wdata, m_wdata);
      check("model.wr_ready", wr_ready, mq.size() < FIFO_DEPTH);
      check("model.disp_valid", disp_valid, m_pv1);
      check("model.disp_data", disp_data, m_pv1 ? m_pd1 : '0);
      check("model.oob_err", oob_err, m_oob);
      check("model.wr_starved", wr_starved, m_full_cycles >= STARVE_LIM);
   endtask

   task automatic drive(input bit dr, input addr_t da, input bit wv, input addr_t wa, input pixel_t wd);
      disp_req = dr; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, '0, 0, '0, '0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ----------------------------------------------------------------------
   // Vector table: inputs for one cycle and the outputs expected after it.
   // ----------------------------------------------------------------------
   typedef struct {
      bit     dr;  addr_t da;
      bit     wv;  addr_t wa;  pixel_t wd;
      bit     e_we; addr_t e_addr; pixel_t e_wdata;
      bit     e_dv; pixel_t e_dd; bit e_rdy;
   } vec_t;

   vec_t vecs [9];

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n_we;
      for (int i = 0; i < FB_DEPTH; i++) begin
         bram[i]   = pixel_t'(i);
         shadow[i] = pixel_t'(i);
      end

      //            dr da  wv wa   wd      we addr wdata   dv dd    rdy
      vecs[0] = '{1, 0,  0, 0,  0,      0, 0,  0,      0, 0,     1};
      vecs[1] = '{1, 1,  0, 0,  0,      0, 1,  0,      1, 0,     1};
      vecs[2] = '{1, 2,  0, 0,  0,      0, 2,  0,      1, 1,     1};
      vecs[3] = '{0, 0,  0, 0,  0,      0, 2,  0,      1, 2,     1};
      vecs[4] = '{0, 0,  1, 10, 'hF00,  0, 2,  0,      0, 0,     1};
      vecs[5] = '{0, 0,  1, 11, 'h0F0,  1, 10, 'hF00,  0, 0,     1};
      vecs[6] = '{0, 0,  1, 12, 'h00F,  1, 11, 'h0F0,  0, 0,     1};
      vecs[7] = '{0, 0,  0, 0,  0,      1, 12, 'h00F,  0, 0,     1};
      vecs[8] = '{0, 0,  0, 0,  0,      0, 12, 0,      0, 0,     1};

      // Reset values.
      do_reset();
      check("rst.disp_valid", disp_valid, 0);
      check("rst.disp_data", disp_data, 0);
      check("rst.wr_ready", wr_ready, 1);
      check("rst.mem_we", mem_we, 0);
      check("rst.mem_addr", mem_addr, 0);
      check("rst.mem_wdata", mem_wdata, 0);
      check("rst.oob_err", oob_err, 0);
      check("rst.wr_starved", wr_starved, 0);

      // Display reads of 0,1,2 followed by three queued writes.
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].dr, vecs[i].da, vecs[i].wv, vecs[i].wa, vecs[i].wd);
         tick();
         check($sformatf("vec%0d.mem_we", i), mem_we, vecs[i].e_we);
         check($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
         if (vecs[i].e_we) check($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         check($sformatf("vec%0d.disp_valid", i), disp_valid, vecs[i].e_dv);
         check($sformatf("vec%0d.disp_data", i), disp_data, vecs[i].e_dd);
         check($sformatf("vec%0d.wr_ready", i), wr_ready, vecs[i].e_rdy);
      end
      check("bram[10]", bram[10], 'hF00);
      check("bram[11]", bram[11], 'h0F0);
      check("bram[12]", bram[12], 'h00F);

      // Display holds the port while 5 pixels are offered.
      for (int k = 0; k < 4; k++) begin
         drive(1, 5, 1, addr_t'(100 + k), pixel_t'('h100 + k));
         check($sformatf("fill.ready%0d", k), wr_ready, 1);
         tick();
      end
      check("fill.full_ready", wr_ready, 0);
      check("fill.no_write", mem_we, 0);
      drive(1, 5, 1, 104, 'h104);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold.ready", wr_ready, 0);
         check("hold.mem_we", mem_we, 0);
      end
      disp_req = 1'b0;
      tick();
      check("drain0.we", mem_we, 1);
      check("drain0.addr", mem_addr, 100);
      check("drain0.ready", wr_ready, 1);
      tick();
      wr_valid = 1'b0;
      check("drain1.addr", mem_addr, 101);
      for (int k = 2; k < 5; k++) begin
         tick();
         check($sformatf("drain%0d.we", k), mem_we, 1);
         check($sformatf("drain%0d.addr", k), mem_addr, 100 + k);
         check($sformatf("drain%0d.wdata", k), mem_wdata, 'h100 + k);
      end
      tick();
      check("drain.done", mem_we, 0);

      // Out-of-range pixel followed by the last valid address.
      drive(0, 0, 1, 76800, 'hABC);
      tick();
      check("oob.set", oob_err, 1);
      check("oob.no_write", mem_we, 0);
      drive(0, 0, 1, 76799, 'h123);
      tick();
      check("oob.sticky", oob_err, 1);
      wr_valid = 1'b0;
      tick();
      check("oob.last_we", mem_we, 1);
      check("oob.last_addr", mem_addr, 76799);
      repeat (5) tick();
      check("oob.still", oob_err, 1);
      check("bram[76799]", bram[76799], 'h123);
      check("bram.no_oob_write", bram_oob_wr, 0);
      do_reset();
      check("oob.cleared", oob_err, 0);

      // Starvation: FIFO held full while the display owns the port.
      for (int k = 0; k < 4; k++) begin
         drive(1, 7, 1, addr_t'(300 + k), pixel_t'('h300 + k));
         tick();
      end
      wr_valid = 1'b0;
      repeat (STARVE_LIM - 1) tick();
      check("starve.before", wr_starved, 0);
      tick();
      check("starve.at_limit", wr_starved, 1);
      disp_req = 1'b0;
      tick();
      check("starve.first_pop", wr_starved, 1);
      tick();
      check("starve.cleared", wr_starved, 0);
      repeat (4) tick();

      // Reset with pixels queued and reads in flight.
      for (int k = 0; k < 3; k++) begin
         drive(1, 9, 1, addr_t'(200 + k), 'h777);
         tick();
      end
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      check("midrst.disp_valid", disp_valid, 0);
      check("midrst.wr_ready", wr_ready, 1);
      check("midrst.mem_we", mem_we, 0);
      n_we = 0;
      repeat (8) begin
         tick();
         if (mem_we) n_we++;
      end
      check("midrst.writes", n_we, 0);
      for (int k = 0; k < 3; k++)
         check($sformatf("midrst.bram%0d", k), bram[200 + k], pixel_t'(200 + k));

      // Random traffic against the model, with one reset in the middle.
      for (int c = 0; c < 2500; c++) begin
         disp_req  = ($urandom_range(1) == 1);
         disp_addr = addr_t'($urandom_range(FB_DEPTH - 1));
         wr_valid  = ($urandom_range(1) == 1);
         wr_addr   = ($urandom_range(15) == 0) ? addr_t'($urandom) : addr_t'($urandom_range(FB_DEPTH - 1));
         wr_data   = pixel_t'($urandom);
         reset     = (c == 1200);
         tick();
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      repeat (8) tick();
      check("end.bram_no_oob_write", bram_oob_wr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
